instr_fetch_unit: RTL

- Upstream neighbour of the multi-cycle control FSM. Holds the PC and the instruction register (IR), and computes the next PC from PCSrc.
- Fetches each instruction from a variable-latency instruction memory with a req/valid handshake. The fetched word sits in a one-entry fetch buffer until IRWre loads it into the IR.
- Drives opCode and the decoded instruction fields to the control unit and register file.

---
 rtl/instr_fetch_unit_pkg.sv | 32 +++
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit_next_pc_logic.sv | 33 +++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch unit:
// PC source selects, fetch FSM states and instruction field positions.
package instr_fetch_unit_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [5:0]  HALT_OPCODE  = 6'b111111;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int SA_MSB  = 10;
    localparam int SA_LSB  = 6;
    localparam int IMM_MSB = 15;
    localparam int IDX_MSB = 25;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_FULL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/valid handshake.
// The fetch unit is the master; the memory is the slave.
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_logic.sv
// Combinational next-PC selection for sequential, branch,
// register-indirect and absolute-jump flow.
module next_pc_logic
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ext_imm,
    input  logic [31:0] reg_target,
    input  logic [25:0] instr_idx,
    output logic [31:0] next_pc
);

    logic [31:0] br_target;
    logic [31:0] jr_target;
    logic [31:0] j_target;

    assign br_target = pc + 32'd4 + (ext_imm << 2);
    assign jr_target = reg_target & ~32'd3;
    assign j_target  = {pc_plus4[31:28], instr_idx, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        unique case (PCSrc)
            PCSRC_SEQ: next_pc = pc_plus4;
            PCSRC_BR:  next_pc = br_target;
            PCSRC_JR:  next_pc = jr_target;
            PCSRC_J:   next_pc = j_target;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC, one-entry fetch buffer and IR for the multi-cycle core,
// fetching over a variable-latency req/valid memory port.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [5:0]  HALT_OP  = HALT_OPCODE
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      PCWre,
    input  logic                      IRWre,
    input  logic [1:0]                PCSrc,
    input  logic [31:0]               ext_imm,
    input  logic [31:0]               reg_target,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus4,
    output logic [31:0]               instr,
    output logic [5:0]                opCode,
    output logic [4:0]                rs,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [4:0]                sa,
    output logic [15:0]               imm16,
    output logic                      fetch_stall,
    output logic                      halted
);

    fetch_state_t state;
    fetch_state_t state_n;

    logic        redir;
    logic        redir_n;
    logic        buf_ld;
    logic        addr_ld;
    logic        buf_vld;
    logic [31:0] fbuf;
    logic [31:0] faddr;
    logic [31:0] next_pc;
    logic [31:0] pc_n;

    assign pc_plus4 = pc + 32'd4;
    assign pc_n     = PCWre ? next_pc : pc;
    assign buf_vld  = (state == F_FULL);

    next_pc_logic u_npc (
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .PCSrc      (PCSrc),
        .ext_imm    (ext_imm),
        .reg_target (reg_target),
        .instr_idx  (instr[IDX_MSB:0]),
        .next_pc    (next_pc)
    );

    // A response for a request whose PC was overwritten is dropped
    // and the fetch is reissued to whatever the PC is now.
    always_comb begin
        state_n       = state;
        redir_n       = redir;
        buf_ld        = 1'b0;
        addr_ld       = 1'b0;
        imem.imem_req = 1'b0;
        unique case (state)
            F_IDLE: begin
                state_n = F_REQ;
                addr_ld = 1'b1;
            end
            F_REQ: begin
                imem.imem_req = 1'b1;
                if (imem.imem_valid) begin
                    if (redir || PCWre) begin
                        redir_n = 1'b0;
                        addr_ld = 1'b1;
                    end else begin
                        buf_ld  = 1'b1;
                        state_n = F_FULL;
                    end
                end else if (PCWre) begin
                    redir_n = 1'b1;
                end
            end
            F_FULL: begin
                if (PCWre) begin
                    state_n = F_REQ;
                    addr_ld = 1'b1;
                end
            end
            default: state_n = F_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= F_IDLE;
            redir <= 1'b0;
            pc    <= RESET_PC;
            instr <= 32'd0;
            fbuf  <= 32'd0;
            faddr <= RESET_PC;
        end else begin
            state <= state_n;
            redir <= redir_n;
            if (PCWre)
                pc <= next_pc;
            if (IRWre && buf_vld)
                instr <= fbuf;
            if (buf_ld)
                fbuf <= imem.imem_rdata;
            if (addr_ld)
                faddr <= pc_n;
        end
    end

    assign imem.imem_addr = faddr;

    assign fetch_stall = IRWre && !buf_vld;
    assign halted      = (instr[OP_MSB:OP_LSB] == HALT_OP);

    assign opCode = instr[OP_MSB:OP_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign sa     = instr[SA_MSB:SA_LSB];
    assign imm16  = instr[IMM_MSB:0];

endmodule
